// File: rtl/uart_ai_window_detector.sv
// Response queue: small valid/ready FIFO holding one response byte per entry.
// Latency: a pushed byte is visible at out_dat on the cycle after the push.
// Backpressure: in_rdy drops when full, unless a pop happens in the same cycle.
module resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat,
  input  logic             out_rdy
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             push;
  logic             pop;

  assign out_vld = (cnt != '0);
  assign out_dat = mem[rd_ptr];
  assign pop     = out_vld && out_rdy;
  assign in_rdy  = (cnt != (AW+1)'(DEPTH)) || pop;
  assign push    = in_vld && in_rdy;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// Classifies UART samples by absolute threshold and/or sliding-window deviation, queues replies to uart_tx.
// Latency: classification on the rx_valid edge; tx_start two cycles later when idle and tx_busy=0.
// Backpressure: none toward uart_rx; replies wait on tx_busy and are dropped (sticky overflow) when the queue is full.
module uart_ai_window_detector #(
  parameter int         DATA_W     = 8,
  parameter int         WIN_DEPTH  = 8,
  parameter int         THRESH     = 100,
  parameter int         DELTA      = 32,
  parameter logic [7:0] RESP_NORM  = 8'h01,
  parameter logic [7:0] RESP_ANOM  = 8'hFF,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              anomaly_flag,
  output logic [15:0]       anomaly_count,
  output logic              warm,
  output logic              overflow
);
  localparam int WIN_AW = $clog2(WIN_DEPTH);
  localparam int SUM_W  = DATA_W + WIN_AW;
  localparam logic [DATA_W-1:0] THRESH_V = DATA_W'(THRESH);
  localparam logic [DATA_W-1:0] DELTA_V  = DATA_W'(DELTA);

  typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} tx_state_t;

  logic [DATA_W-1:0] win_mem [WIN_DEPTH];
  logic [WIN_AW-1:0] win_ptr;
  logic [SUM_W-1:0]  win_sum;
  logic [DATA_W-1:0] mean;
  logic [DATA_W-1:0] evicted;
  logic [DATA_W-1:0] diff;
  logic              abs_hit;
  logic              dev_hit;
  logic              hit;

  tx_state_t         state_q;
  tx_state_t         state_d;
  logic              fifo_in_rdy;
  logic              fifo_out_vld;
  logic [7:0]        fifo_out_dat;
  logic              fifo_pop;

  // Classify the incoming sample against the window as it stood before this sample.
  always_comb begin
    mean    = DATA_W'(win_sum >> WIN_AW);
    evicted = warm ? win_mem[win_ptr] : '0;
    diff    = (rx_data >= mean) ? (rx_data - mean) : (mean - rx_data);
    abs_hit = rx_data > THRESH_V;
    dev_hit = warm && (diff > DELTA_V);
    case (mode)
      2'd1:    hit = dev_hit;
      2'd2:    hit = abs_hit || dev_hit;
      default: hit = abs_hit;
    endcase
  end

  // Circular sample buffer, running sum and warm flag; pointer wrap doubles as the fill count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_DEPTH; i++) win_mem[i] <= '0;
      win_ptr <= '0;
      win_sum <= '0;
      warm    <= 1'b0;
    end else if (rx_valid) begin
      win_mem[win_ptr] <= rx_data;
      win_ptr          <= win_ptr + WIN_AW'(1);
      win_sum          <= win_sum + SUM_W'(rx_data) - SUM_W'(evicted);
      if (win_ptr == WIN_AW'(WIN_DEPTH - 1)) warm <= 1'b1;
    end
  end

  // Anomaly statistics and sticky drop indicator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anomaly_flag  <= 1'b0;
      anomaly_count <= '0;
      overflow      <= 1'b0;
    end else if (rx_valid) begin
      anomaly_flag <= hit;
      if (hit && (anomaly_count != 16'hFFFF)) anomaly_count <= anomaly_count + 16'd1;
      if (!fifo_in_rdy) overflow <= 1'b1;
    end
  end

  resp_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (rx_valid),
    .in_dat  (hit ? RESP_ANOM : RESP_NORM),
    .in_rdy  (fifo_in_rdy),
    .out_vld (fifo_out_vld),
    .out_dat (fifo_out_dat),
    .out_rdy (fifo_pop)
  );

  // TX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // TX next state and launch strobe; WAIT_HI absorbs a late busy so a byte is never relaunched.
  always_comb begin
    state_d  = state_q;
    tx_start = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE:    if (fifo_out_vld && !tx_busy) state_d = START;
      START: begin
        tx_start = 1'b1;
        fifo_pop = 1'b1;
        state_d  = WAIT_HI;
      end
      WAIT_HI: if (tx_busy)  state_d = WAIT_LO;
      WAIT_LO: if (!tx_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the queue head when launching so tx_data is stable through START and holds afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               tx_data <= '0;
    else if (state_q == IDLE && state_d == START) tx_data <= fifo_out_dat;
  end
endmodule

// File: tb/tb_uart_ai_window_detector.sv
// Bench for uart_ai_window_detector: directed samples, queued expected reply bytes.
// A monitor compares every tx_start byte against the queue; a simple uart_tx model drives busy.
// Flag, count, warm and overflow are checked directly after each sample edge.
module tb_uart_ai_window_detector;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        anomaly_flag;
  logic [15:0] anomaly_count;
  logic        warm;
  logic        overflow;

  logic        model_busy = 1'b0;
  logic        hold_busy = 1'b0;
  logic [7:0]  exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          exp_cnt = 0;

  assign tx_busy = model_busy | hold_busy;

  always #5 clk = ~clk;

  uart_ai_window_detector dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mode          (mode),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .tx_busy       (tx_busy),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .anomaly_flag  (anomaly_flag),
    .anomaly_count (anomaly_count),
    .warm          (warm),
    .overflow      (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // uart_tx stand-in: busy rises one cycle after the launch and lasts three cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        @(negedge clk);
        model_busy = 1'b1;
        repeat (3) @(negedge clk);
        model_busy = 1'b0;
      end
    end
  end

  // Monitor: every launch must match the oldest outstanding expected byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && tx_start === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_unexpected: got %02h want no launch", tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", 32'(tx_data), 32'(e));
        end
      end
    end
  end

  // Wait until all expected bytes are sent and the line has been quiet for a while.
  task automatic drain();
    int stable = 0;
    for (int i = 0; i < 1000 && stable < 8; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !tx_busy) stable++;
      else stable = 0;
    end
    total++;
    if (stable < 8) begin
      bad++;
      $display("FAIL drain_timeout: pending=%0d want 0", exp_q.size());
    end
  endtask

  // One isolated sample followed by direct checks and a full drain.
  task automatic send(input logic [1:0] m, input logic [7:0] v, input logic [7:0] eb, input logic ef);
    @(negedge clk);
    mode = m;
    rx_data = v;
    rx_valid = 1'b1;
    exp_q.push_back(eb);
    @(negedge clk);
    rx_valid = 1'b0;
    if (ef && exp_cnt != 65535) exp_cnt++;
    check("flag", 32'(anomaly_flag), 32'(ef));
    check("count", 32'(anomaly_count), 32'(exp_cnt));
    drain();
  endtask

  task automatic check_all_zero();
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_flag", 32'(anomaly_flag), 32'd0);
    check("rst_count", 32'(anomaly_count), 32'd0);
    check("rst_warm", 32'(warm), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
  endtask

  initial begin
    logic [7:0] burst [6];
    int n;
    burst = '{8'd10, 8'd200, 8'd20, 8'd210, 8'd30, 8'd220};

    repeat (3) @(negedge clk);
    check_all_zero();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1/T2: absolute threshold including the strict boundary.
    send(2'd0, 8'd50,  8'h01, 1'b0);
    send(2'd0, 8'd150, 8'hFF, 1'b1);
    send(2'd0, 8'd100, 8'h01, 1'b0);
    send(2'd0, 8'd101, 8'hFF, 1'b1);

    // Fresh window for the deviation tests.
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // T3: cold window never flags in mode 1; warm on the eighth sample.
    for (int i = 0; i < 8; i++) begin
      send(2'd1, 8'd100, 8'h01, 1'b0);
      if (i == 6) check("warm_before", 32'(warm), 32'd0);
    end
    check("warm_after", 32'(warm), 32'd1);
    send(2'd1, 8'd140, 8'hFF, 1'b1);   // mean 100, dev 40
    send(2'd1, 8'd130, 8'h01, 1'b0);   // mean 105, dev 25
    send(2'd1, 8'd76,  8'h01, 1'b0);   // mean 108, dev 32: not strictly above
    send(2'd1, 8'd72,  8'hFF, 1'b1);   // mean 105, dev 33

    // T4: mode comparison on a window of 120s.
    for (int i = 0; i < 8; i++) send(2'd2, 8'd120, 8'hFF, 1'b1);
    send(2'd2, 8'd120, 8'hFF, 1'b1);   // absolute only
    send(2'd1, 8'd120, 8'h01, 1'b0);   // no deviation
    send(2'd3, 8'd120, 8'hFF, 1'b1);   // mode 3 behaves as absolute
    send(2'd2, 8'd60,  8'hFF, 1'b1);   // deviation only (mean 120)
    send(2'd0, 8'd90,  8'h01, 1'b0);
    check("overflow_clear", 32'(overflow), 32'd0);

    // T5: six back-to-back samples while uart_tx is busy; only four fit.
    hold_busy = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mode = 2'd0;
      rx_data = burst[i];
      rx_valid = 1'b1;
      if (i < 4) exp_q.push_back(burst[i] > 8'd100 ? 8'hFF : 8'h01);
      if (burst[i] > 8'd100) exp_cnt++;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    check("overflow_set", 32'(overflow), 32'd1);
    check("burst_count", 32'(anomaly_count), 32'(exp_cnt));
    check("burst_flag", 32'(anomaly_flag), 32'd1);
    hold_busy = 1'b0;
    drain();

    // Counter saturation: reach 16'hFFFF, then two more anomalies.
    hold_busy = 1'b1;
    n = 65535 - exp_cnt;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mode = 2'd0;
      rx_data = 8'd255;
      rx_valid = 1'b1;
      if (i < 4) exp_q.push_back(8'hFF);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    check("count_at_max", 32'(anomaly_count), 32'hFFFF);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rx_data = 8'd255;
      rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    check("count_saturated", 32'(anomaly_count), 32'hFFFF);
    hold_busy = 1'b0;
    drain();

    // T6: asynchronous reset with two replies queued and a warm window.
    hold_busy = 1'b1;
    @(negedge clk);
    rx_data = 8'd10;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_data = 8'd250;
    @(negedge clk);
    rx_valid = 1'b0;
    check("pre_rst_warm", 32'(warm), 32'd1);
    check("pre_rst_flag", 32'(anomaly_flag), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero();
    exp_q.delete();
    exp_cnt = 0;
    hold_busy = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send(2'd1, 8'd200, 8'h01, 1'b0);  // cold window: no deviation hit
    check("post_rst_warm", 32'(warm), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
